// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
package tdm_pkg;

    // HUNT: waiting for a start-of-frame word; RUN: collecting slots.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int N_CH_DEF = 4;
    localparam int W_DEF    = 8;

endpackage

// File: rtl/tdm_demux_slot_decoder.sv
// Binary slot index to one-hot write enables for the shadow register bank.
module slot_decoder
    import tdm_pkg::*;
#(
    parameter  int N_CH = N_CH_DEF,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic [SW-1:0]   idx,
    input  logic            en,
    output logic [N_CH-1:0] onehot
);

    // One bit set at the slot position when a word is being accepted.
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive side: tracks slot sequence, buffers partial frames in a shadow
// bank and publishes a whole frame on y in one edge when the last slot lands.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter  int N_CH = N_CH_DEF,
    parameter  int W    = W_DEF,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    din,
    input  logic            din_valid,
    input  logic            sof,
    output logic [N_CH*W-1:0] y,
    output logic            y_valid,
    output logic [SW-1:0]   slot,
    output logic            err
);

    state_t          state, state_n;
    logic [SW-1:0]   slot_n;
    logic            wr_en;
    logic [SW-1:0]   wr_idx;
    logic            err_n;
    logic [N_CH-1:0] wr_hot;
    logic            load;
    logic [W-1:0]    shadow [N_CH-1];
    logic [N_CH*W-1:0] frame;

    // Next-state, slot advance and write steering for each accepted word.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        wr_en   = 1'b0;
        wr_idx  = slot;
        err_n   = 1'b0;
        unique case (state)
            HUNT: begin
                if (din_valid && sof) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    slot_n  = SW'(1);
                    state_n = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    if (sof) begin
                        // Early sof abandons the partial frame and restarts at slot 0.
                        err_n  = (slot != '0);
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        slot_n = SW'(1);
                    end else if (slot == '0) begin
                        // Frame boundary without sof: alignment lost.
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        // N_CH is a power of two, so the increment wraps to 0 after the last slot.
                        wr_en  = 1'b1;
                        wr_idx = slot;
                        slot_n = slot + SW'(1);
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    slot_decoder #(.N_CH(N_CH)) u_dec (
        .idx    (wr_idx),
        .en     (wr_en),
        .onehot (wr_hot)
    );

    // A write to the last slot completes the frame; that word bypasses the bank.
    assign load = wr_hot[N_CH-1];

    for (genvar k = 0; k < N_CH - 1; k++) begin : g_frame
        assign frame[k*W +: W] = shadow[k];
    end
    assign frame[(N_CH-1)*W +: W] = din;

    // State, slot counter, pulses, shadow bank and output frame register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            slot    <= '0;
            err     <= 1'b0;
            y_valid <= 1'b0;
            y       <= '0;
            for (int k = 0; k < N_CH - 1; k++) shadow[k] <= '0;
        end else begin
            state   <= state_n;
            slot    <= slot_n;
            err     <= err_n;
            y_valid <= load;
            if (load) y <= frame;
            for (int k = 0; k < N_CH - 1; k++)
                if (wr_hot[k]) shadow[k] <= din;
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Bench: three tdm_demux instances (N_CH=4/W=8, N_CH=2/W=8, N_CH=8/W=16) share
// one stimulus stream; each is checked every cycle against a word-counting model.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        sof;

    logic [31:0]  y4;  logic yv4; logic [1:0] slot4; logic err4;
    logic [15:0]  y2;  logic yv2; logic [0:0] slot2; logic err2;
    logic [127:0] y8;  logic yv8; logic [2:0] slot8; logic err8;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state per instance
    logic [15:0]  m_buf [3][8];
    int           m_cnt [3];
    bit           m_hunt[3];
    logic [127:0] e_y   [3];
    bit           e_yv  [3];
    bit           e_err [3];

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(4), .W(8)) u4 (
        .clk(clk), .rst(rst), .din(din[7:0]), .din_valid(din_valid), .sof(sof),
        .y(y4), .y_valid(yv4), .slot(slot4), .err(err4));
    tdm_demux #(.N_CH(2), .W(8)) u2 (
        .clk(clk), .rst(rst), .din(din[7:0]), .din_valid(din_valid), .sof(sof),
        .y(y2), .y_valid(yv2), .slot(slot2), .err(err2));
    tdm_demux #(.N_CH(8), .W(16)) u8 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .y(y8), .y_valid(yv8), .slot(slot8), .err(err8));

    function automatic int n_of(int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 8;
    endfunction

    function automatic int w_of(int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic logic [127:0] obs_y(int i);
        case (i)
            0:       return 128'(y4);
            1:       return 128'(y2);
            default: return y8;
        endcase
    endfunction

    function automatic logic obs_yv(int i);
        return (i == 0) ? yv4 : (i == 1) ? yv2 : yv8;
    endfunction

    function automatic logic obs_err(int i);
        return (i == 0) ? err4 : (i == 1) ? err2 : err8;
    endfunction

    function automatic int obs_slot(int i);
        case (i)
            0:       return int'(slot4);
            1:       return int'(slot2);
            default: return int'(slot8);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_hunt[i] = 1'b1;
            e_y[i]    = '0;
            e_yv[i]   = 1'b0;
            e_err[i]  = 1'b0;
        end
    endtask

    // One accepted-or-idle cycle as seen by a channel-count-n receiver.
    task automatic model_step(int i, bit v, bit s, logic [15:0] d);
        logic [15:0] dd;
        int n, w;
        n = n_of(i);
        w = w_of(i);
        dd = (w == 16) ? d : (d & 16'h00FF);
        e_yv[i]  = 1'b0;
        e_err[i] = 1'b0;
        if (!v) return;
        if (m_hunt[i]) begin
            if (s) begin
                m_buf[i][0] = dd;
                m_cnt[i]    = 1;
                m_hunt[i]   = 1'b0;
            end
        end else if (s) begin
            e_err[i]    = (m_cnt[i] != 0);
            m_buf[i][0] = dd;
            m_cnt[i]    = 1;
        end else if (m_cnt[i] == 0) begin
            e_err[i]  = 1'b1;
            m_hunt[i] = 1'b1;
        end else begin
            m_buf[i][m_cnt[i]] = dd;
            m_cnt[i]++;
            if (m_cnt[i] == n) begin
                e_y[i] = '0;
                for (int k = 0; k < n; k++)
                    e_y[i] = e_y[i] | (128'(m_buf[i][k]) << (k * w));
                e_yv[i]  = 1'b1;
                m_cnt[i] = 0;
            end
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            assert (obs_y(i) === e_y[i]) else begin
                n_fail++;
                $error("FAIL %s[n=%0d] y: got %h want %h", tag, n_of(i), obs_y(i), e_y[i]);
            end
            n_cmp++;
            assert (obs_yv(i) === e_yv[i]) else begin
                n_fail++;
                $error("FAIL %s[n=%0d] y_valid: got %b want %b", tag, n_of(i), obs_yv(i), e_yv[i]);
            end
            n_cmp++;
            assert (obs_err(i) === e_err[i]) else begin
                n_fail++;
                $error("FAIL %s[n=%0d] err: got %b want %b", tag, n_of(i), obs_err(i), e_err[i]);
            end
            n_cmp++;
            assert (obs_slot(i) === (m_hunt[i] ? 0 : m_cnt[i])) else begin
                n_fail++;
                $error("FAIL %s[n=%0d] slot: got %0d want %0d", tag, n_of(i), obs_slot(i),
                       m_hunt[i] ? 0 : m_cnt[i]);
            end
        end
    endtask

    task automatic step(bit v, bit s, logic [15:0] d, string tag);
        rst = 1'b0; din_valid = v; sof = s; din = d;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, v, s, d);
        #1;
        check_all(tag);
    endtask

    // Reset cycle with live-looking inputs: reset must win.
    task automatic do_reset(string tag);
        rst = 1'b1; din_valid = 1'b1; sof = 1'b1; din = 16'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic idle(int cycles, string tag);
        for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, 16'($urandom), tag);
    endtask

    // Words base+0 .. base+cnt-1 (sof on the first) with gap idle cycles between.
    task automatic frame(logic [15:0] base, int cnt, int gap, string tag);
        for (int k = 0; k < cnt; k++) begin
            step(1'b1, k == 0, base + 16'(k), tag);
            if (k != cnt - 1) idle(gap, tag);
        end
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; sof = 1'b0;
        model_reset();
        do_reset("reset");

        // A0,B1,C2,D3 with sof on A0
        step(1'b1, 1'b1, 16'hA0, "f1");
        step(1'b1, 1'b0, 16'hB1, "f1");
        step(1'b1, 1'b0, 16'hC2, "f1");
        step(1'b1, 1'b0, 16'hD3, "f1");
        idle(2, "f1_tail");

        // Same frame with 3-cycle gaps, plus a stray sof while idle
        do_reset("reset2");
        step(1'b1, 1'b1, 16'hA0, "gap");
        idle(3, "gap");
        step(1'b0, 1'b1, 16'h77, "gap_sof_idle");
        step(1'b1, 1'b0, 16'hB1, "gap");
        idle(3, "gap");
        step(1'b1, 1'b0, 16'hC2, "gap");
        idle(3, "gap");
        step(1'b1, 1'b0, 16'hD3, "gap");
        idle(2, "gap_tail");

        // Words without sof after reset are dropped silently
        do_reset("reset3");
        step(1'b1, 1'b0, 16'h11, "nosof");
        step(1'b1, 1'b0, 16'h22, "nosof");

        // Early sof mid-frame
        step(1'b1, 1'b1, 16'h01, "early");
        step(1'b1, 1'b0, 16'h02, "early");
        step(1'b1, 1'b1, 16'h0A, "early");
        step(1'b1, 1'b0, 16'h0B, "early");
        step(1'b1, 1'b0, 16'h0C, "early");
        step(1'b1, 1'b0, 16'h0D, "early");
        idle(1, "early_tail");

        // Full frame, then a word missing its sof, then recovery
        do_reset("reset4");
        frame(16'h40, 4, 0, "miss");
        step(1'b1, 1'b0, 16'h55, "miss");
        step(1'b1, 1'b0, 16'h56, "miss_hunt");
        frame(16'h60, 4, 0, "recover");
        idle(1, "recover_tail");

        // Reset mid-frame discards the partial frame
        frame(16'h90, 2, 0, "midrst");
        do_reset("midrst_rst");
        frame(16'hC0, 4, 1, "fresh");

        // Full-width frames for the 8-channel instance
        frame(16'h1234, 8, 0, "wide");
        frame(16'hBEE0, 8, 2, "wide_gap");
        idle(1, "wide_tail");

        // Randomized traffic with occasional reset
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset("rnd_rst");
            else
                step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                     16'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
